vfd_compositor: RTL and testbench

VFD_COMPOSITOR -- requirements
Module: vfd_compositor

---
 rtl/vfd_pkg.sv | 41 ++++
 rtl/vfd_if.sv | 31 +++
 rtl/vfd_seg_cache.sv | 48 ++++
 rtl/vfd_compositor.sv | 152 +++++++++++++++
 tb/tb_vfd_compositor.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vfd_pkg.sv
// Shared definitions for the VFD compositor.
// Holds the FSM state encoding, the unlit-pixel dimming modes, the bus
// widths used by the interface, and the RGB332 dimming function.
package vfd_pkg;

    localparam int SDRAM_AW = 25;   // SDRAM word address width
    localparam int VRAM_AW  = 19;   // VRAM pixel index width
    localparam int PIX_W    = 8;    // RGB332 pixel width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MREQ   = 3'd1,
        ST_MLATCH = 3'd2,
        ST_BREQ   = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIM_BLACK = 2'd0,
        DIM_MSB   = 2'd1,
        DIM_HALF  = 2'd2,
        DIM_PASS  = 2'd3
    } dim_mode_t;

    // Treatment of a background pixel that is not covered by a lit segment.
    // RGB332 layout: d[7:5] red, d[4:2] green, d[1:0] blue.
    function automatic logic [PIX_W-1:0] dim_pixel(input logic [PIX_W-1:0] d,
                                                   input dim_mode_t      mode);
        logic [PIX_W-1:0] r;
        r = '0;
        case (mode)
            DIM_BLACK: r = 8'h00;
            DIM_MSB:   r = {2'b00, d[7], 2'b00, d[4], 1'b0, d[1]};
            DIM_HALF:  r = {1'b0, d[7:6], 1'b0, d[4:3], 1'b0, d[1]};
            DIM_PASS:  r = d;
            default:   r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vfd_if.sv
// Memory-side bus of the compositor: SDRAM read port and VRAM write port.
//   sdram_addr  25  read word address
//   sdram_rd     1  read strobe
//   sdram_data   8  read data
//   vfd_addr    19  VRAM pixel index
//   vfd_dout     8  RGB332 pixel
//   vfd_vram_we  1  VRAM write strobe
// Strobe semantics: the compositor qualifies its own strobes with rdy, so a
// read or write happens exactly in a cycle where the strobe is high; read
// data is expected on the next rdy=1 cycle after the read strobe and is held
// by the memory side until the following read.
interface vfd_if;
    logic [vfd_pkg::SDRAM_AW-1:0] sdram_addr;
    logic                         sdram_rd;
    logic [vfd_pkg::PIX_W-1:0]    sdram_data;
    logic [vfd_pkg::VRAM_AW-1:0]  vfd_addr;
    logic [vfd_pkg::PIX_W-1:0]    vfd_dout;
    logic                         vfd_vram_we;

    modport master (
        output sdram_addr, sdram_rd,
        input  sdram_data,
        output vfd_addr, vfd_dout, vfd_vram_we
    );

    modport slave (
        input  sdram_addr, sdram_rd,
        output sdram_data,
        input  vfd_addr, vfd_dout, vfd_vram_we
    );
endinterface

// File: rtl/vfd_seg_cache.sv
// Per-grid segment latch with persistence decay.
//   clk, rst_n  clock, async active-low reset
//   grid_sel    grid strobes (only an exactly one-hot value writes)
//   seg         segment levels for the strobed grid
//   cache       latched segments, cache[g][s]
// Each grid's counter is reloaded on its strobe and counts down every cycle
// otherwise; the entry clears on the cycle the counter reaches zero.
// PERSIST=0 leaves the counters at zero, so entries never decay.
module vfd_seg_cache #(
    parameter int NUM_GRIDS = 10,
    parameter int NUM_SEGS  = 15,
    parameter int PERSIST   = 4096
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_GRIDS-1:0]                grid_sel,
    input  logic [NUM_SEGS-1:0]                 seg,
    output logic [NUM_GRIDS-1:0][NUM_SEGS-1:0]  cache
);

    localparam int CNT_W = (PERSIST > 0) ? $clog2(PERSIST + 1) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERSIST);

    logic [NUM_GRIDS-1:0][CNT_W-1:0] cnt;
    logic                            one_hot;

    assign one_hot = $onehot(grid_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache <= '0;
            cnt   <= '0;
        end else begin
            for (int g = 0; g < NUM_GRIDS; g++) begin
                if (one_hot && grid_sel[g]) begin
                    cache[g] <= seg;
                    cnt[g]   <= RELOAD;
                end else if (cnt[g] != '0) begin
                    cnt[g] <= cnt[g] - CNT_W'(1);
                    if (cnt[g] == CNT_W'(1)) begin
                        cache[g] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vfd_compositor.sv
// Composites a VFD segment image over a background picture.
// For every pixel p it reads a mask byte (grid/segment coordinate) and a
// background byte from SDRAM, then writes the background to VRAM either as
// is (segment lit) or dimmed (segment unlit).
//   clk, rst_n  clock, async active-low reset
//   rdy         global advance enable for FSM and memory strobes
//   enable      frame start, sampled in IDLE
//   dim_mode    unlit-pixel treatment, sampled in WRITE
//   grid_sel    grid strobes; seg  segment levels
//   bus         SDRAM read / VRAM write port (vfd_if.master)
//   frame_done  one-cycle pulse after the last pixel write
//   state_dbg   current FSM state
module vfd_compositor
    import vfd_pkg::*;
#(
    parameter int NUM_GRIDS = 10,
    parameter int NUM_SEGS  = 15,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BG_BASE   = 0,
    parameter int MASK_BASE = 640 * 480,
    parameter int PERSIST   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 enable,
    input  logic [1:0]           dim_mode,
    input  logic [NUM_GRIDS-1:0] grid_sel,
    input  logic [NUM_SEGS-1:0]  seg,
    vfd_if.master                bus,
    output logic                 frame_done,
    output state_t               state_dbg
);

    localparam int NPIX = H_RES * V_RES;
    localparam int P_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [P_W-1:0]      P_LAST = P_W'(NPIX - 1);
    localparam logic [SDRAM_AW-1:0] MASK_A = SDRAM_AW'(MASK_BASE);
    localparam logic [SDRAM_AW-1:0] BG_A   = SDRAM_AW'(BG_BASE);

    state_t                              state;
    logic [P_W-1:0]                      p;
    logic                                seg_en;
    logic                                rd_q;
    logic                                we_q;
    logic [SDRAM_AW-1:0]                 sdram_addr_q;
    logic [VRAM_AW-1:0]                  vfd_addr_q;
    logic [PIX_W-1:0]                    dout_q;
    logic [NUM_GRIDS-1:0][NUM_SEGS-1:0]  cache;
    logic [3:0]                          col;
    logic [3:0]                          row;
    logic [PIX_W-1:0]                    pix;

    vfd_seg_cache #(
        .NUM_GRIDS (NUM_GRIDS),
        .NUM_SEGS  (NUM_SEGS),
        .PERSIST   (PERSIST)
    ) u_cache (
        .clk      (clk),
        .rst_n    (rst_n),
        .grid_sel (grid_sel),
        .seg      (seg),
        .cache    (cache)
    );

    assign col = bus.sdram_data[7:4];
    assign row = bus.sdram_data[3:0];
    assign pix = seg_en ? bus.sdram_data
                        : dim_pixel(bus.sdram_data, dim_mode_t'(dim_mode));

    // Strobes are registered with the state but only asserted in rdy cycles,
    // so a stalled cycle never repeats a read or a write.
    assign bus.sdram_rd    = rd_q & rdy;
    assign bus.vfd_vram_we = we_q & rdy;
    assign bus.sdram_addr  = sdram_addr_q;
    assign bus.vfd_addr    = vfd_addr_q;
    // Background data only arrives in the WRITE cycle, so the pixel is passed
    // through combinationally there and held afterwards.
    assign bus.vfd_dout    = (state == ST_WRITE) ? pix : dout_q;
    assign state_dbg       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            p            <= '0;
            seg_en       <= 1'b0;
            rd_q         <= 1'b0;
            we_q         <= 1'b0;
            sdram_addr_q <= '0;
            vfd_addr_q   <= '0;
            dout_q       <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (rdy) begin
                case (state)
                    ST_IDLE: begin
                        p <= '0;
                        if (enable) begin
                            state        <= ST_MREQ;
                            rd_q         <= 1'b1;
                            sdram_addr_q <= MASK_A;
                        end
                    end
                    ST_MREQ: begin
                        state <= ST_MLATCH;
                        rd_q  <= 1'b0;
                    end
                    ST_MLATCH: begin
                        // Reads the registered cache, i.e. the value before
                        // any strobe landing on this same edge.
                        if (int'(col) < NUM_GRIDS && int'(row) < NUM_SEGS) begin
                            seg_en <= cache[col][row];
                        end else begin
                            seg_en <= 1'b0;
                        end
                        state        <= ST_BREQ;
                        rd_q         <= 1'b1;
                        sdram_addr_q <= BG_A + SDRAM_AW'(p);
                    end
                    ST_BREQ: begin
                        state      <= ST_WRITE;
                        rd_q       <= 1'b0;
                        we_q       <= 1'b1;
                        vfd_addr_q <= VRAM_AW'(p);
                    end
                    ST_WRITE: begin
                        we_q   <= 1'b0;
                        dout_q <= pix;
                        if (p == P_LAST) begin
                            p          <= '0;
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            p            <= p + P_W'(1);
                            state        <= ST_MREQ;
                            rd_q         <= 1'b1;
                            sdram_addr_q <= MASK_A + SDRAM_AW'(p + P_W'(1));
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        rd_q  <= 1'b0;
                        we_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vfd_compositor.sv
// Bench for vfd_compositor on a 4x1 frame with fast segment decay.
module tb_vfd_compositor;
    import vfd_pkg::*;

    localparam int NG   = 10;
    localparam int NS   = 15;
    localparam int HR   = 4;
    localparam int VR   = 1;
    localparam int NPIX = HR * VR;
    localparam int BGB  = 0;
    localparam int MKB  = 16;
    localparam int PERS = 8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rdy = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    dim_mode = 2'd0;
    logic [NG-1:0] grid_sel = '0;
    logic [NS-1:0] seg = '0;
    logic          frame_done;
    state_t        state_dbg;

    vfd_if bus();

    vfd_compositor #(
        .NUM_GRIDS (NG),
        .NUM_SEGS  (NS),
        .H_RES     (HR),
        .V_RES     (VR),
        .BG_BASE   (BGB),
        .MASK_BASE (MKB),
        .PERSIST   (PERS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .enable     (enable),
        .dim_mode   (dim_mode),
        .grid_sel   (grid_sel),
        .seg        (seg),
        .bus        (bus),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]    mem [0:31];
    logic [NS-1:0] m_cache [NG];
    int            m_cnt [NG];
    int            mp;
    bit            next_mask;
    bit            pend_mask;
    logic [7:0]    pend_byte;
    logic [19:0]   exp_q [$];        // {lit, pixel index}
    int            wr_in_frame;
    int            frames_done = 0;
    logic [7:0]    log_dout [$];
    logic [18:0]   log_addr [$];

    function automatic logic [7:0] ref_dim(input logic [7:0] d, input int mode);
        int r, g, b;
        r = int'(d) / 32;
        g = (int'(d) / 4) % 8;
        b = int'(d) % 4;
        case (mode)
            0: begin r = 0; g = 0; b = 0; end
            1: begin r = r / 4; g = g / 4; b = b / 2; end
            2: begin r = r / 2; g = g / 2; b = b / 2; end
            default: ;
        endcase
        return 8'(r * 32 + g * 4 + b);
    endfunction

    function automatic bit ref_lit(input logic [7:0] mb);
        int c, r;
        c = int'(mb) / 16;
        r = int'(mb) % 16;
        if (c < NG && r < NS) return m_cache[c][r];
        return 1'b0;
    endfunction

    // Monitor, memory responder and scoreboard; runs mid-cycle when every
    // input and output of the current cycle is stable.
    always @(negedge clk) begin : monitor
        logic [19:0] e;
        logic [7:0]  bg;
        logic [7:0]  ed;
        int          ea;
        int          idx;
        bit          strobed;
        if (!rst_n) begin
            for (int g = 0; g < NG; g++) begin
                m_cache[g] = '0;
                m_cnt[g]   = 0;
            end
            mp = 0; next_mask = 1'b1; pend_mask = 1'b0; wr_in_frame = 0;
            exp_q.delete();
            bus.sdram_data = 8'h00;
        end else begin
            if (!rdy)
                chk("strobe_without_rdy", {30'd0, bus.sdram_rd, bus.vfd_vram_we}, 32'd0);
            if (frame_done) begin
                chk("frame_pixel_count", wr_in_frame, NPIX);
                wr_in_frame = 0;
                frames_done++;
            end
            if (rdy && bus.vfd_vram_we) begin
                if (exp_q.size() == 0) begin
                    chk("write_unexpected", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    bg = mem[BGB + int'(e[18:0])];
                    ed = e[19] ? bg : ref_dim(bg, int'(dim_mode));
                    chk("vfd_addr", bus.vfd_addr, e[18:0]);
                    chk("vfd_dout", bus.vfd_dout, ed);
                end
                log_dout.push_back(bus.vfd_dout);
                log_addr.push_back(bus.vfd_addr);
                wr_in_frame++;
            end
            if (rdy && pend_mask) begin
                exp_q.push_back({ref_lit(pend_byte), 19'(mp)});
                pend_mask = 1'b0;
            end
            if (rdy && bus.sdram_rd) begin
                ea = next_mask ? MKB + mp : BGB + mp;
                chk("sdram_addr", bus.sdram_addr, ea);
                if (next_mask) begin
                    pend_mask = 1'b1;
                    pend_byte = mem[ea];
                end else begin
                    mp = (mp + 1) % NPIX;
                end
                next_mask = !next_mask;
                idx = int'(bus.sdram_addr);
                bus.sdram_data = (idx < 32) ? mem[idx] : 8'h00;
            end
            // segment cache as seen on the coming edge
            for (int g = 0; g < NG; g++) begin
                strobed = ($countones(grid_sel) == 1) && grid_sel[g];
                if (strobed) begin
                    m_cache[g] = seg;
                    m_cnt[g]   = PERS;
                end else if (m_cnt[g] > 0) begin
                    m_cnt[g]--;
                    if (m_cnt[g] == 0) m_cache[g] = '0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit toggle_rdy = 1'b0;
    bit rand_stim  = 1'b0;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (toggle_rdy) rdy = ~rdy;
            if (rand_stim) begin
                rdy = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) dim_mode = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0:       grid_sel = '0;
                    1:       grid_sel = NG'($urandom);
                    default: grid_sel = NG'(1) << $urandom_range(0, NG - 1);
                endcase
                seg = NS'($urandom);
            end
        end
    endtask

    task automatic run_frame(input int budget, input bit pulse_grid, output int cycles);
        int start;
        start  = frames_done;
        enable = 1'b1;
        rdy    = 1'b1;
        cyc(1);
        enable = 1'b0;
        if (pulse_grid) grid_sel = '0;
        cycles = 1;
        while (frames_done == start && cycles < budget) begin
            cyc(1);
            cycles++;
        end
        chk("frame_done_seen", 32'(frames_done != start), 32'd1);
    endtask

    task automatic fill_mem(input logic [7:0] mask, input logic [7:0] bg);
        for (int i = 0; i < NPIX; i++) begin
            mem[MKB + i] = mask;
            mem[BGB + i] = bg;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_sdram_rd"},    bus.sdram_rd, 32'd0);
        chk({tag, "_vram_we"},     bus.vfd_vram_we, 32'd0);
        chk({tag, "_sdram_addr"},  bus.sdram_addr, 32'd0);
        chk({tag, "_vfd_addr"},    bus.vfd_addr, 32'd0);
        chk({tag, "_vfd_dout"},    bus.vfd_dout, 32'd0);
        chk({tag, "_frame_done"},  frame_done, 32'd0);
        chk({tag, "_state"},       state_dbg, ST_IDLE);
    endtask

    typedef struct {
        logic [1:0]    dm;
        logic [NG-1:0] gs;
        logic [NS-1:0] sg;
        logic [7:0]    mask;
        logic [7:0]    bg;
        logic [7:0]    exp_px;
    } vec_t;

    vec_t vecs [11];

    // ---------------- test sequence ----------------
    initial begin : main
        int cycles;
        int fd0;
        int bound;
        vecs[0]  = '{2'd0, 10'h001, 15'h0001, 8'h00, 8'hFF, 8'hFF};
        vecs[1]  = '{2'd1, 10'h001, 15'h0000, 8'h00, 8'hFF, 8'h25};
        vecs[2]  = '{2'd2, 10'h001, 15'h0000, 8'h00, 8'hFF, 8'h6D};
        vecs[3]  = '{2'd0, 10'h001, 15'h0000, 8'h00, 8'hFF, 8'h00};
        vecs[4]  = '{2'd2, 10'h001, 15'h7FFF, 8'hFF, 8'hFF, 8'h6D};
        vecs[5]  = '{2'd0, 10'h001, 15'h0008, 8'h03, 8'h5A, 8'h5A};
        vecs[6]  = '{2'd1, 10'h001, 15'h7FFF, 8'h0F, 8'hFF, 8'h25};
        vecs[7]  = '{2'd0, 10'h004, 15'h0008, 8'h23, 8'hC3, 8'hC3};
        vecs[8]  = '{2'd2, 10'h200, 15'h4000, 8'hA0, 8'h92, 8'h49};
        vecs[9]  = '{2'd0, 10'h200, 15'h4000, 8'h9E, 8'h3C, 8'h3C};
        vecs[10] = '{2'd1, 10'h200, 15'h4000, 8'h9D, 8'hFF, 8'h25};
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        // reset state
        cyc(2);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        rdy   = 1'b1;
        cyc(2);

        // table-driven single-frame vectors
        for (int v = 0; v < 11; v++) begin
            fill_mem(vecs[v].mask, vecs[v].bg);
            dim_mode = vecs[v].dm;
            grid_sel = vecs[v].gs;
            seg      = vecs[v].sg;
            cyc(2);
            log_dout.delete();
            log_addr.delete();
            run_frame(60, 1'b0, cycles);
            if (v == 0) chk("frame_done_within_20", 32'(cycles <= 20), 32'd1);
            chk($sformatf("vec%0d_writes", v), log_dout.size(), NPIX);
            for (int i = 0; i < NPIX && i < log_dout.size(); i++) begin
                chk($sformatf("vec%0d_addr%0d", v, i), log_addr[i], i);
                chk($sformatf("vec%0d_dout%0d", v, i), log_dout[i], vecs[v].exp_px);
            end
            grid_sel = '0;
            cyc(12);
        end

        // decay: one strobe of grid 0 together with frame start
        fill_mem(8'h00, 8'hFF);
        dim_mode = 2'd0;
        grid_sel = 10'h001;
        seg      = 15'h0001;
        log_dout.delete();
        log_addr.delete();
        run_frame(60, 1'b1, cycles);
        chk("decay_writes", log_dout.size(), NPIX);
        if (log_dout.size() == NPIX) begin
            chk("decay_px0", log_dout[0], 8'hFF);
            chk("decay_px1", log_dout[1], 8'hFF);
            chk("decay_px2", log_dout[2], 8'h00);
            chk("decay_px3", log_dout[3], 8'h00);
        end
        cyc(12);

        // rdy alternating every cycle
        grid_sel = 10'h001;
        seg      = 15'h0001;
        dim_mode = 2'd1;
        mem[MKB + 1] = 8'h05;
        mem[BGB + 2] = 8'hB6;
        log_dout.delete();
        log_addr.delete();
        toggle_rdy = 1'b1;
        run_frame(80, 1'b0, cycles);
        toggle_rdy = 1'b0;
        rdy = 1'b1;
        chk("halfrate_writes", log_dout.size(), NPIX);
        for (int i = 0; i < NPIX && i < log_addr.size(); i++)
            chk($sformatf("halfrate_addr%0d", i), log_addr[i], i);
        chk("halfrate_slow", 32'(cycles > 30), 32'd1);
        cyc(3);

        // asynchronous reset in the middle of a frame
        fill_mem(8'h00, 8'hFF);
        log_dout.delete();
        log_addr.delete();
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        bound = 0;
        while (log_dout.size() < 2 && bound < 40) begin
            cyc(1);
            bound++;
        end
        chk("midframe_reached", 32'(log_dout.size() >= 2), 32'd1);
        fd0 = frames_done;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        cyc(3);
        chk("midreset_no_done", frames_done, fd0);
        rst_n = 1'b1;
        cyc(1);
        log_dout.delete();
        log_addr.delete();
        run_frame(60, 1'b0, cycles);
        chk("restart_writes", log_addr.size(), NPIX);
        if (log_addr.size() > 0) chk("restart_addr0", log_addr[0], 0);
        grid_sel = '0;
        cyc(12);

        // randomized frames against the model
        rand_stim = 1'b1;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                if ($urandom_range(0, 3) != 0)
                    mem[MKB + i] = {4'($urandom_range(0, NG - 1)), 4'($urandom_range(0, NS - 1))};
                else
                    mem[MKB + i] = 8'($urandom);
                mem[BGB + i] = 8'($urandom);
            end
            run_frame(300, 1'b0, cycles);
            cyc($urandom_range(1, 4));
        end
        rand_stim = 1'b0;
        rdy = 1'b1;
        cyc(4);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
